// File: rtl/trng_pkg.sv
// Shared defaults and debiaser state encoding for the TRNG conditioner.
package trng_pkg;

  localparam int unsigned TRNG_DEPTH_DEF      = 16;
  localparam int unsigned TRNG_SAMPLE_DIV_DEF = 4;
  localparam int unsigned TRNG_RCT_CUTOFF_DEF = 32;

  typedef enum logic {
    VN_IDLE       = 1'b0,
    VN_HAVE_FIRST = 1'b1
  } vn_state_t;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs strobed samples, emits the first bit of each
// unequal pair and throws away equal pairs.
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic strobe,
  input  logic sample,
  output logic push,
  output logic push_bit
);

  vn_state_t r_state;
  vn_state_t w_state_nxt;
  logic      r_first;
  logic      w_first_nxt;

  // State and stored first bit; reset drops any half-formed pair.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= VN_IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= w_first_nxt;
    end
  end

  // Pairing decisions; push is only raised on the strobe that completes a pair.
  always_comb begin
    w_state_nxt = r_state;
    w_first_nxt = r_first;
    push        = 1'b0;
    push_bit    = r_first;
    case (r_state)
      VN_IDLE: begin
        if (strobe) begin
          w_first_nxt = sample;
          w_state_nxt = VN_HAVE_FIRST;
        end
      end
      VN_HAVE_FIRST: begin
        if (strobe) begin
          push        = (sample != r_first);
          w_state_nxt = VN_IDLE;
        end
      end
      default: w_state_nxt = VN_IDLE;
    endcase
  end

endmodule

// File: rtl/trng_conditioner.sv
// TRNG conditioner: synchronizes a ring-oscillator bit, samples it on a
// divided strobe, debiases it, runs a repetition-count health test and
// buffers the conditioned bits in a small FIFO for the consumer.
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int unsigned DEPTH      = TRNG_DEPTH_DEF,
  parameter int unsigned SAMPLE_DIV = TRNG_SAMPLE_DIV_DEF,
  parameter int unsigned RCT_CUTOFF = TRNG_RCT_CUTOFF_DEF
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         raw_bit,
  input  logic                         trng_req,
  output logic                         trng_bit,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         underflow,
  output logic                         health_fail
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [7:0]    DIV_LAST  = 8'(SAMPLE_DIV - 1);
  localparam logic [7:0]    RCT_MAX   = 8'(RCT_CUTOFF);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  // Run length grows by one per equal sample and sticks at the cutoff.
  function automatic logic [7:0] rep_sat_inc(input logic [7:0] cnt);
    return (cnt >= RCT_MAX) ? RCT_MAX : cnt + 8'd1;
  endfunction

  logic          r_sync_p0;
  logic          r_sync_p1;
  logic [7:0]    r_div;
  logic          w_strobe;
  logic          r_prev;
  logic [7:0]    r_rep_cnt;
  logic [7:0]    w_rep_nxt;
  logic          r_health_fail;
  logic          w_vn_push;
  logic          w_vn_bit;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_en;
  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_underflow;

  // Two-flop synchronizer for the asynchronous entropy input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= raw_bit;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Sample divider; the strobe lands on the SAMPLE_DIV-th edge after release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= 8'd0;
    end else if (w_strobe) begin
      r_div <= 8'd0;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  assign w_strobe = (r_div == DIV_LAST);

  // A zero count means no sample seen yet, so the first sample starts a run.
  always_comb begin
    w_rep_nxt = 8'd1;
    if (r_rep_cnt != 8'd0 && r_sync_p1 == r_prev) begin
      w_rep_nxt = rep_sat_inc(r_rep_cnt);
    end
  end

  // Repetition-count health test; the failure flag is sticky until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prev        <= 1'b0;
      r_rep_cnt     <= 8'd0;
      r_health_fail <= 1'b0;
    end else if (w_strobe) begin
      r_prev    <= r_sync_p1;
      r_rep_cnt <= w_rep_nxt;
      if (w_rep_nxt == RCT_MAX) begin
        r_health_fail <= 1'b1;
      end
    end
  end

  trng_vn_debias u_vn_debias (
    .clk      (clk),
    .resetn   (resetn),
    .strobe   (w_strobe),
    .sample   (r_sync_p1),
    .push     (w_vn_push),
    .push_bit (w_vn_bit)
  );

  assign w_push  = w_vn_push && !r_health_fail;
  assign w_pop   = trng_req && (r_level != '0);
  assign w_wr_en = w_push && ((r_level != LVL_FULL) || w_pop);

  // FIFO pointers and level; a health failure flushes and freezes the buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (r_health_fail) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage; contents are only ever read when the level says they are valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_vn_bit;
    end
  end

  // Sticky underflow on any request made against an empty buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_underflow <= 1'b0;
    end else if (trng_req && (r_level == '0)) begin
      r_underflow <= 1'b1;
    end
  end

  assign trng_bit    = (r_level != '0) ? r_mem[r_rd_ptr] : 1'b0;
  assign fifo_level  = r_level;
  assign underflow   = r_underflow;
  assign health_fail = r_health_fail;

endmodule

// File: tb/tb_trng_conditioner.sv
// Self-checking bench for trng_conditioner with a queue scoreboard of
// expected conditioned bits built from the raw samples the bench drives.
module tb_trng_conditioner;

  localparam int DEPTH = 16;
  localparam int SDIV  = 4;
  localparam int RCT   = 32;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       raw_bit = 1'b0;
  logic       trng_req = 1'b0;
  logic       trng_bit;
  logic [4:0] fifo_level;
  logic       underflow;
  logic       health_fail;

  always #5 clk = ~clk;

  trng_conditioner #(
    .DEPTH      (DEPTH),
    .SAMPLE_DIV (SDIV),
    .RCT_CUTOFF (RCT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .raw_bit     (raw_bit),
    .trng_req    (trng_req),
    .trng_bit    (trng_bit),
    .fifo_level  (fifo_level),
    .underflow   (underflow),
    .health_fail (health_fail)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic q_exp[$];
  logic m_have, m_first, m_prev, m_fail, m_uf;
  int   m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_exp.delete();
    m_have = 1'b0; m_first = 1'b0; m_prev = 1'b0;
    m_fail = 1'b0; m_uf = 1'b0; m_cnt = 0;
  endtask

  // Asserts reset between edges, checks outputs clear at once, releases on a negedge.
  task automatic do_reset();
    #2;
    resetn   = 1'b0;
    trng_req = 1'b0;
    raw_bit  = 1'b0;
    model_reset();
    #1;
    check_eq("rst_trng_bit",    32'(trng_bit),    32'd0);
    check_eq("rst_fifo_level",  32'(fifo_level),  32'd0);
    check_eq("rst_underflow",   32'(underflow),   32'd0);
    check_eq("rst_health_fail", 32'(health_fail), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Holds one raw value for one strobe window; optionally pops on the strobe edge.
  task automatic send_sample(input logic b, input logic pop_on_strobe);
    logic fail_before;
    logic gen;
    logic head;
    raw_bit = b;
    repeat (SDIV - 1) @(posedge clk);
    #1;
    if (pop_on_strobe) begin
      trng_req = 1'b1;
      head = (q_exp.size() > 0) ? q_exp[0] : 1'b0;
      check_eq("strobe_head", 32'(trng_bit), 32'(head));
    end
    @(posedge clk);
    #1;
    trng_req = 1'b0;
    fail_before = m_fail;
    if (fail_before) q_exp.delete();
    if (pop_on_strobe) begin
      if (q_exp.size() > 0) void'(q_exp.pop_front());
      else m_uf = 1'b1;
    end
    if (m_cnt == 0 || b != m_prev) m_cnt = 1;
    else if (m_cnt < RCT) m_cnt++;
    m_prev = b;
    if (m_cnt == RCT) m_fail = 1'b1;
    gen = 1'b0;
    if (!m_have) begin
      m_first = b;
      m_have  = 1'b1;
    end else begin
      m_have = 1'b0;
      gen    = (b != m_first);
    end
    if (gen && !fail_before && q_exp.size() < DEPTH) q_exp.push_back(m_first);
  endtask

  task automatic send_pair(input logic a, input logic b, input logic pop_on_strobe);
    send_sample(a, 1'b0);
    send_sample(b, pop_on_strobe);
  endtask

  // Pops n bits, comparing each head against the scoreboard.
  task automatic pop_check(input int n);
    logic exp_bit;
    for (int i = 0; i < n; i++) begin
      trng_req = 1'b1;
      if (q_exp.size() > 0) exp_bit = q_exp.pop_front();
      else begin exp_bit = 1'b0; m_uf = 1'b1; end
      check_eq("pop_bit", 32'(trng_bit), 32'(exp_bit));
      @(posedge clk);
      #1;
    end
    trng_req = 1'b0;
  endtask

  initial begin
    logic v;

    // Alternating raw stream fills the FIFO with zeros and then holds at full.
    do_reset();
    for (int i = 0; i < 48; i++) begin
      send_sample(((i % 2) == 1), 1'b0);
      if ((i % 2) == 1) check_eq("alt_level", 32'(fifo_level), 32'(q_exp.size()));
    end
    check_eq("alt_full", 32'(fifo_level), 32'(DEPTH));
    check_eq("alt_health", 32'(health_fail), 32'd0);

    // Preload 1,0,1,1 and read it back.
    do_reset();
    send_pair(1'b1, 1'b0, 1'b0);
    send_pair(1'b0, 1'b1, 1'b0);
    send_pair(1'b1, 1'b0, 1'b0);
    send_pair(1'b1, 1'b0, 1'b0);
    check_eq("pre_level", 32'(fifo_level), 32'd4);
    pop_check(4);
    check_eq("pre_drained", 32'(fifo_level), 32'd0);
    check_eq("pre_underflow", 32'(underflow), 32'd0);

    // Request against an empty FIFO.
    do_reset();
    @(posedge clk);
    #1;
    check_eq("uf_before", 32'(underflow), 32'd0);
    trng_req = 1'b1;
    check_eq("uf_bit", 32'(trng_bit), 32'd0);
    @(posedge clk);
    #1;
    trng_req = 1'b0;
    check_eq("uf_set", 32'(underflow), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("uf_sticky", 32'(underflow), 32'd1);
    check_eq("uf_level", 32'(fifo_level), 32'd0);

    // Push and pop together while empty: underflow and the bit is kept.
    do_reset();
    send_pair(1'b1, 1'b0, 1'b1);
    check_eq("pe_underflow", 32'(underflow), 32'(m_uf));
    check_eq("pe_level", 32'(fifo_level), 32'(q_exp.size()));
    pop_check(1);

    // Overfill, then push and pop together at full, then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      v = 1'($urandom_range(0, 1));
      send_pair(v, ~v, 1'b0);
    end
    check_eq("full_level", 32'(fifo_level), 32'(DEPTH));
    v = 1'($urandom_range(0, 1));
    send_pair(v, ~v, 1'b1);
    check_eq("full_pushpop_level", 32'(fifo_level), 32'(DEPTH));
    pop_check(DEPTH);
    check_eq("full_drained", 32'(fifo_level), 32'd0);

    // Constant ones trip the repetition test on the 32nd strobe and flush the FIFO.
    do_reset();
    send_pair(1'b1, 1'b0, 1'b0);
    send_pair(1'b0, 1'b1, 1'b0);
    send_pair(1'b1, 1'b0, 1'b0);
    check_eq("hf_pre_level", 32'(fifo_level), 32'd3);
    for (int k = 1; k <= RCT; k++) begin
      send_sample(1'b1, 1'b0);
      if (k == RCT - 1) check_eq("hf_not_yet", 32'(health_fail), 32'd0);
    end
    check_eq("hf_set", 32'(health_fail), 32'(m_fail));
    check_eq("hf_level_same_cycle", 32'(fifo_level), 32'd3);
    @(posedge clk);
    #1;
    check_eq("hf_flushed", 32'(fifo_level), 32'd0);
    send_pair(1'b1, 1'b0, 1'b0);
    check_eq("hf_no_push", 32'(fifo_level), 32'd0);
    check_eq("hf_sticky", 32'(health_fail), 32'd1);

    // Mid-stream reset with 9 bits buffered and half a pair pending.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      v = 1'($urandom_range(0, 1));
      send_pair(v, ~v, 1'b0);
    end
    check_eq("mr_level", 32'(fifo_level), 32'd9);
    send_sample(1'b1, 1'b0);
    do_reset();
    send_pair(1'b1, 1'b0, 1'b0);
    check_eq("mr_fresh_level", 32'(fifo_level), 32'(q_exp.size()));
    pop_check(1);
    check_eq("mr_underflow", 32'(underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_conditioner.md
TRNG_CONDITIONER -- requirements
Module: trng_conditioner

Interface
REQ-001 Parameter DEPTH, default 16: bit-FIFO depth in entries, power of two, range 4..64.
REQ-002 Parameter SAMPLE_DIV, default 4: clocks between raw-entropy samples, range 1..255.
REQ-003 Parameter RCT_CUTOFF, default 32: identical consecutive raw samples that trip the repetition-count health test, range 2..255.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous assert, active-low.
REQ-006 raw_bit  in  1  ring-oscillator entropy bit, asynchronous to clk.
REQ-007 trng_req  in  1  consumer pop request, one bit per clk while high.
REQ-008 trng_bit  out  1  FIFO head bit; 0 when FIFO is empty.
REQ-009 fifo_level  out  clog2(DEPTH+1)  number of buffered conditioned bits.
REQ-010 underflow  out  1  sticky; set when a pop is requested while FIFO is empty.
REQ-011 health_fail  out  1  sticky; set when the repetition-count test trips.

Function
REQ-012 raw_bit SHALL pass through a 2-flop synchronizer before any use.
REQ-013 A sample strobe SHALL assert for one cycle every SAMPLE_DIV clocks, driven by a counter that wraps from SAMPLE_DIV-1 to 0; the synchronized bit is sampled only on a strobe.
REQ-014 The von Neumann debiaser SHALL have two states, IDLE and HAVE_FIRST; in IDLE a strobe stores the sample and moves to HAVE_FIRST.
REQ-015 In HAVE_FIRST a strobe whose sample differs from the stored bit SHALL push the stored bit (01->0, 10->1) and return to IDLE.
REQ-016 In HAVE_FIRST a strobe whose sample equals the stored bit SHALL discard both bits and return to IDLE.
REQ-017 The repetition counter SHALL reset to 1 on every strobe whose sample differs from the previous sample, increment on equal samples, and saturate at RCT_CUTOFF.
REQ-018 When the repetition counter reaches RCT_CUTOFF, health_fail SHALL set on that edge.
REQ-019 The cycle after health_fail sets, the FIFO SHALL empty (fifo_level=0), and no further pushes SHALL occur until reset.
REQ-020 trng_bit SHALL be the combinational FIFO head.
REQ-021 A pop SHALL occur on an edge where trng_req=1 and fifo_level>0; the new head is visible the next cycle.
REQ-022 A push while fifo_level=DEPTH with no simultaneous pop SHALL be dropped, and fifo_level SHALL be unchanged.
REQ-023 A simultaneous push and pop at full SHALL accept both, leaving fifo_level=DEPTH.
REQ-024 A simultaneous push and pop at empty SHALL set underflow, drive trng_bit=0 in that cycle, and store the pushed bit (fifo_level=1).
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH or go below 0.
REQ-026 trng_req=1 with fifo_level=0 SHALL set underflow on that edge, with no pointer change.

Reset
REQ-027 While resetn=0, all of the following SHALL be 0: trng_bit, fifo_level, underflow, health_fail, the pointers, the divider, the repetition counter, and the synchronizer flops; the debiaser SHALL be in IDLE.
REQ-028 A reset mid-operation SHALL discard buffered bits and any half-formed von Neumann pair.
REQ-029 The first strobe after reset release SHALL occur SAMPLE_DIV cycles after release; the repetition test SHALL treat the first sample as a new run (counter=1).

Structure
REQ-030 Package trng_pkg SHALL hold the parameter defaults and the debiaser state enum (VN_IDLE, VN_HAVE_FIRST).
REQ-031 The debiaser SHALL be sub-module trng_vn_debias (inputs: strobe and sample; outputs: push and push_bit); the FIFO, divider and health test stay in trng_conditioner.

Verification
REQ-032 Alternating raw 0,1,0,1… with SAMPLE_DIV=4 and trng_req=0 -> one push of bit 0 every 8 cycles after the synchronizer delay; fifo_level reaches 16 and holds; health_fail=0.
REQ-033 Constant raw=1 -> no pushes; health_fail sets on the 32nd strobe; fifo_level=0 thereafter.
REQ-034 Preload pattern 1,0,1,1 (raw pairs 10,01,10,10), then trng_req=1 for 4 cycles -> trng_bit sequence 1,0,1,1; fifo_level falls to 0; underflow=0.
REQ-035 trng_req=1 with an empty FIFO -> underflow=1 next cycle and stays 1; trng_bit=0.
REQ-036 FIFO full (16 entries), with a push strobe and trng_req=1 in the same cycle -> fifo_level stays 16; the popped bit equals the oldest entry.
REQ-037 Assert resetn=0 mid-stream with fifo_level=9 and the debiaser in HAVE_FIRST -> all outputs 0 immediately (asynchronous); after release the first push needs a fresh pair.
